hazard_unit: RTL



---
 rtl/pipe_pkg.sv | 39 +++
 rtl/hazard_unit_if.sv | 34 +++
 rtl/hazard_track.sv | 34 +++
 rtl/hazard_unit.sv | 85 ++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline encodings for the 5-stage core: result sources, forwarding
// selects and register-index width, plus the forwarding priority function.
package pipe_pkg;

    localparam int REG_AW = 5;

    typedef logic [REG_AW-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    // Memory stage wins over Writeback; x0 is hardwired zero and never forwarded.
    function automatic fwd_sel_e fwd_select(
        input logic     reg_write_m,
        input reg_idx_t rd_m,
        input logic     reg_write_w,
        input reg_idx_t rd_w,
        input reg_idx_t rs
    );
        fwd_sel_e sel;
        sel = FWD_RF;
        if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
            sel = FWD_M;
        end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Decode/Execute identifiers flowing into the hazard unit and the stall,
// flush and forward controls flowing back into the pipeline registers.
interface hazard_unit_if;
    import pipe_pkg::*;

    reg_idx_t    Rs1D;
    reg_idx_t    Rs2D;
    reg_idx_t    Rs1E;
    reg_idx_t    Rs2E;
    reg_idx_t    RdE;
    logic        RegWriteE;
    logic [1:0]  ResultSrcE;
    logic        PCSrcE;

    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic        FlushE;
    logic [1:0]  ForwardAE;
    logic [1:0]  ForwardBE;

    // master: the datapath that supplies register ids and obeys the controls.
    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RegWriteE, ResultSrcE, PCSrcE,
        input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE
    );

    // slave: the hazard unit itself.
    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RegWriteE, ResultSrcE, PCSrcE,
        output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE
    );

endinterface

// File: rtl/hazard_track.sv
// Shadow copies of the Memory and Writeback destination state, advanced every
// edge from the Execute inputs; a flushed D/E shows up here one cycle later.
module hazard_track
    import pipe_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  reg_idx_t   RdE,
    input  logic       RegWriteE,
    input  logic [1:0] ResultSrcE,
    output reg_idx_t   RdM,
    output logic       RegWriteM,
    output logic [1:0] ResultSrcM,
    output reg_idx_t   RdW,
    output logic       RegWriteW
);

    always_ff @(posedge clk) begin
        if (reset) begin
            RdM        <= '0;
            RegWriteM  <= 1'b0;
            ResultSrcM <= RES_ALU;
            RdW        <= '0;
            RegWriteW  <= 1'b0;
        end else begin
            RdM        <= RdE;
            RegWriteM  <= RegWriteE;
            ResultSrcM <= ResultSrcE;
            RdW        <= RdM;
            RegWriteW  <= RegWriteM;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage core: operand forwarding, load-use stall,
// control flush and saturating stall/flush event counters.
module hazard_unit
    import pipe_pkg::*;
#(
    parameter int         CNT_W    = 16,
    parameter logic [1:0] LOAD_SRC = 2'b01
) (
    input  logic             clk,
    input  logic             reset,
    hazard_unit_if.slave     hif,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    reg_idx_t   rd_m;
    logic       reg_write_m;
    logic [1:0] result_src_m;
    reg_idx_t   rd_w;
    logic       reg_write_w;

    hazard_track u_track (
        .clk        (clk),
        .reset      (reset),
        .RdE        (hif.RdE),
        .RegWriteE  (hif.RegWriteE),
        .ResultSrcE (hif.ResultSrcE),
        .RdM        (rd_m),
        .RegWriteM  (reg_write_m),
        .ResultSrcM (result_src_m),
        .RdW        (rd_w),
        .RegWriteW  (reg_write_w)
    );

    logic     lw_stall;
    logic     stall;
    fwd_sel_e fwd_a;
    fwd_sel_e fwd_b;

    // RegWriteE is deliberately not part of the load test.
    assign lw_stall = (hif.ResultSrcE == LOAD_SRC) && (hif.RdE != '0) &&
                      ((hif.Rs1D == hif.RdE) || (hif.Rs2D == hif.RdE));

    // A taken branch makes the Decode instruction wrong-path, so it is flushed, not held.
    assign stall = lw_stall && !hif.PCSrcE && !reset;

    assign fwd_a = fwd_select(reg_write_m, rd_m, reg_write_w, rd_w, hif.Rs1E);
    assign fwd_b = fwd_select(reg_write_m, rd_m, reg_write_w, rd_w, hif.Rs2E);

    always_comb begin
        hif.StallF    = 1'b0;
        hif.StallD    = 1'b0;
        hif.FlushD    = 1'b1;
        hif.FlushE    = 1'b1;
        hif.ForwardAE = FWD_RF;
        hif.ForwardBE = FWD_RF;
        if (!reset) begin
            hif.StallF    = stall;
            hif.StallD    = stall;
            hif.FlushD    = hif.PCSrcE;
            hif.FlushE    = stall || hif.PCSrcE;
            hif.ForwardAE = fwd_a;
            hif.ForwardBE = fwd_b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (hif.PCSrcE && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    // Forwarding a load's address from M means a load-use stall was missed.
    a_no_load_fwd_from_m : assert property (@(posedge clk) disable iff (reset)
        !(((fwd_a == FWD_M) || (fwd_b == FWD_M)) && (result_src_m == LOAD_SRC)));

endmodule
